// File: rtl/fb_draw_ctrl_pkg.sv
// Shared definitions for the framebuffer draw controller: geometry, opcodes,
// FSM states, the command word layout and coordinate clamping helpers.
package fb_draw_ctrl_pkg;

  localparam int FB_W = 160;
  localparam int FB_H = 100;

  localparam logic [7:0] X_MAX = 8'(FB_W - 1);
  localparam logic [6:0] Y_MAX = 7'(FB_H - 1);

  typedef enum logic [7:0] {
    OP_PIXEL  = 8'h00,
    OP_ANCHOR = 8'h01,
    OP_FILL   = 8'h02,
    OP_CLEAR  = 8'h03
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  // Bit 23 of the command word carries no meaning.
  typedef struct packed {
    logic [7:0] op;
    logic       rsvd;
    logic [6:0] y;
    logic [7:0] x;
    logic [7:0] colour;
  } cmd_t;

  function automatic logic [7:0] clamp_x(input logic [7:0] x);
    return (x > X_MAX) ? X_MAX : x;
  endfunction

  function automatic logic [6:0] clamp_y(input logic [6:0] y);
    return (y > Y_MAX) ? Y_MAX : y;
  endfunction

endpackage

// File: rtl/fb_draw_ctrl_if.sv
// Command handshake from the UART multibyte receiver into the draw controller.
interface fb_draw_ctrl_if;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ack;

  modport master (output cmd_data, output cmd_valid, input  cmd_ack);
  modport slave  (input  cmd_data, input  cmd_valid, output cmd_ack);
endinterface

// File: rtl/fb_rect_scanner.sv
// Row-major rectangle walker: holds the pixel currently being written and
// flags the final pixel of the rectangle.
module fb_rect_scanner (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [6:0] y0,
  input  logic [6:0] y1,
  output logic [7:0] cur_x,
  output logic [6:0] cur_y,
  output logic       last
);

  logic [7:0] x_lo, x_hi;
  logic [6:0] y_hi;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_x <= '0;
      cur_y <= '0;
      x_lo  <= '0;
      x_hi  <= '0;
      y_hi  <= '0;
    end else if (start) begin
      cur_x <= x0;
      cur_y <= y0;
      x_lo  <= x0;
      x_hi  <= x1;
      y_hi  <= y1;
    end else if (step) begin
      if (cur_x == x_hi) begin
        cur_x <= x_lo;
        // y never steps past the clamped bottom row.
        if (cur_y != y_hi) cur_y <= cur_y + 7'd1;
      end else begin
        cur_x <= cur_x + 8'd1;
      end
    end
  end

  assign last = (cur_x == x_hi) && (cur_y == y_hi);

endmodule

// File: rtl/fb_draw_ctrl.sv
// Command sequencer owning the framebuffer write port: single pixel writes
// plus anchored rectangle fills and full-screen clears at one pixel per clk.
module fb_draw_ctrl
  import fb_draw_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  fb_draw_ctrl_if.slave     cmd,
  input  logic              abort,
  output logic [14:0]       waddr,
  output logic [7:0]        wdata,
  output logic              wen,
  output logic              busy
);

  state_e      state_q, state_d;
  cmd_t        c;
  logic        accept;
  logic [14:0] anchor_q;
  logic [14:0] pix_addr_q;
  logic        pix_wen_q;

  logic        scan_start;
  logic [7:0]  rx0, rx1, ax, bx, scan_x;
  logic [6:0]  ry0, ry1, ay, by, scan_y;
  logic        scan_last;
  logic        unused_rsvd;

  assign c           = cmd.cmd_data;
  assign unused_rsvd = c.rsvd;
  assign cmd.cmd_ack = (state_q == ST_IDLE) && !reset;
  assign accept      = cmd.cmd_valid && cmd.cmd_ack;

  // Rectangle bounds: both corners clamped to the visible area, then ordered.
  always_comb begin
    ax = clamp_x(anchor_q[7:0]);
    ay = clamp_y(anchor_q[14:8]);
    bx = clamp_x(c.x);
    by = clamp_y(c.y);
    if (c.op == OP_CLEAR) begin
      rx0 = '0;
      rx1 = X_MAX;
      ry0 = '0;
      ry1 = Y_MAX;
    end else begin
      rx0 = (ax < bx) ? ax : bx;
      rx1 = (ax < bx) ? bx : ax;
      ry0 = (ay < by) ? ay : by;
      ry1 = (ay < by) ? by : ay;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    scan_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (c.op == OP_FILL || c.op == OP_CLEAR)) begin
          state_d    = ST_FILL;
          scan_start = 1'b1;
        end
      end
      ST_FILL: begin
        if (abort || scan_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      anchor_q   <= '0;
      pix_addr_q <= '0;
      wdata      <= '0;
      pix_wen_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_wen_q <= accept && (c.op == OP_PIXEL);
      if (accept) begin
        case (c.op)
          OP_PIXEL: begin
            pix_addr_q <= {c.y, c.x};
            wdata      <= c.colour;
          end
          OP_ANCHOR: anchor_q <= {c.y, c.x};
          OP_FILL,
          OP_CLEAR:  wdata    <= c.colour;
          default:   ;
        endcase
      end
    end
  end

  fb_rect_scanner u_scanner (
    .clk   (clk),
    .reset (reset),
    .start (scan_start),
    .step  (state_q == ST_FILL),
    .x0    (rx0),
    .x1    (rx1),
    .y0    (ry0),
    .y1    (ry1),
    .cur_x (scan_x),
    .cur_y (scan_y),
    .last  (scan_last)
  );

  // During a fill the scanner position is the write address; otherwise the
  // last pixel address is held.
  assign busy  = (state_q == ST_FILL);
  assign wen   = pix_wen_q || busy;
  assign waddr = busy ? {scan_y, scan_x} : pix_addr_q;

endmodule

// File: tb/tb_fb_draw_ctrl.sv
// Directed bench for fb_draw_ctrl: pixel, anchor/fill, clear, clamping,
// abort, async reset mid-fill, held commands and unknown opcodes.
module tb_fb_draw_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        abort;
  logic [14:0] waddr;
  logic [7:0]  wdata;
  logic        wen;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fb_draw_ctrl_if cmd_if ();

  fb_draw_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd_if.slave),
    .abort (abort),
    .waddr (waddr),
    .wdata (wdata),
    .wen   (wen),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for ack, return at the cycle after accept.
  task automatic send(input logic [31:0] d);
    int guard;
    guard = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_data  = d;
    while (!cmd_if.cmd_ack && guard < 20000) begin
      tick();
      guard++;
    end
    check("ack_wait", 32'(cmd_if.cmd_ack), 32'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Follow a burst of writes against a row-major model of the expected rect.
  task automatic scan_writes(input logic [7:0] x0, input logic [7:0] x1,
                             input logic [6:0] y0,
                             output int cnt, output int oob, output int order_err,
                             output logic [14:0] last_addr);
    logic [7:0] ex;
    logic [6:0] ey;
    ex = x0;
    ey = y0;
    cnt = 0;
    oob = 0;
    order_err = 0;
    last_addr = '0;
    while (wen && cnt < 20000) begin
      if (waddr[7:0] >= 8'd160 || waddr[14:8] >= 7'd100) oob++;
      if (waddr !== {ey, ex} || busy !== 1'b1) order_err++;
      last_addr = waddr;
      if (ex == x1) begin
        ex = x0;
        ey = ey + 7'd1;
      end else begin
        ex = ex + 8'd1;
      end
      cnt++;
      tick();
    end
  endtask

  int          cnt, oob, oerr;
  logic [14:0] last_a;
  logic [14:0] exp6 [6];

  initial begin
    reset = 1'b1;
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data  = '0;
    exp6 = '{15'h0202, 15'h0203, 15'h0204, 15'h0302, 15'h0303, 15'h0304};

    // Reset state
    #12;
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(cmd_if.cmd_ack), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("idle_ack", 32'(cmd_if.cmd_ack), 32'd1);
    tick();

    // Single PIXEL
    send(32'h0012_34AB);
    check("pix_wen", 32'(wen), 32'd1);
    check("pix_waddr", 32'(waddr), 32'h1234);
    check("pix_wdata", 32'(wdata), 32'hAB);
    tick();
    check("pix_wen_drop", 32'(wen), 32'd0);

    // Back-to-back PIXELs, one per cycle
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_data  = 32'h0001_0211;
    tick();
    check("b2b_wen0", 32'(wen), 32'd1);
    check("b2b_addr0", 32'(waddr), 32'h0102);
    cmd_if.cmd_data = 32'h0003_0422;
    tick();
    cmd_if.cmd_valid = 1'b0;
    check("b2b_wen1", 32'(wen), 32'd1);
    check("b2b_addr1", 32'(waddr), 32'h0304);
    check("b2b_data1", 32'(wdata), 32'h22);
    tick();
    check("b2b_end", 32'(wen), 32'd0);

    // ANCHOR (2,3) then FILL to (4,2): six writes, ack back on the 7th cycle
    send(32'h0103_0200);
    check("anchor_nowrite", 32'(wen), 32'd0);
    send(32'h0202_0455);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("fill_wen%0d", i), 32'(wen), 32'd1);
      check($sformatf("fill_addr%0d", i), 32'(waddr), 32'(exp6[i]));
      check($sformatf("fill_busy%0d", i), 32'(busy), 32'd1);
      check($sformatf("fill_noack%0d", i), 32'(cmd_if.cmd_ack), 32'd0);
      tick();
    end
    check("fill_data", 32'(wdata), 32'h55);
    check("fill_done_ack", 32'(cmd_if.cmd_ack), 32'd1);
    check("fill_done_busy", 32'(busy), 32'd0);
    check("fill_done_wen", 32'(wen), 32'd0);

    // CLEAR: whole screen, 16000 consecutive writes
    send(32'h0300_000F);
    scan_writes(8'd0, 8'd159, 7'd0, cnt, oob, oerr, last_a);
    check("clear_count", 32'(cnt), 32'd16000);
    check("clear_last", 32'(last_a), 32'h639F);
    check("clear_order", 32'(oerr), 32'd0);
    check("clear_oob", 32'(oob), 32'd0);
    check("clear_ack", 32'(cmd_if.cmd_ack), 32'd1);

    // Clamped FILL from anchor (150,90) to (200,120)
    send(32'h015A_9600);
    send(32'h0278_C833);
    scan_writes(8'd150, 8'd159, 7'd90, cnt, oob, oerr, last_a);
    check("clamp_count", 32'(cnt), 32'd100);
    check("clamp_oob", 32'(oob), 32'd0);
    check("clamp_order", 32'(oerr), 32'd0);
    check("clamp_last", 32'(last_a), 32'h639F);

    // Abort on the 3rd write of a CLEAR
    send(32'h0300_0007);
    check("abort_w1", 32'(waddr), 32'h0000);
    tick();
    check("abort_w2", 32'(waddr), 32'h0001);
    tick();
    abort = 1'b1;
    check("abort_w3_wen", 32'(wen), 32'd1);
    check("abort_w3_addr", 32'(waddr), 32'h0002);
    tick();
    abort = 1'b0;
    check("abort_wen", 32'(wen), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ack", 32'(cmd_if.cmd_ack), 32'd1);
    tick();
    check("abort_quiet", 32'(wen), 32'd0);

    // Async reset mid-fill, then anchor must be back at (0,0)
    send(32'h0300_0009);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("rstmid_wen", 32'(wen), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_waddr", 32'(waddr), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    send(32'h0201_0177);
    scan_writes(8'd0, 8'd1, 7'd0, cnt, oob, oerr, last_a);
    check("rstmid_fill_cnt", 32'(cnt), 32'd4);
    check("rstmid_fill_order", 32'(oerr), 32'd0);
    check("rstmid_fill_last", 32'(last_a), 32'h0101);

    // PIXEL held valid during a 2-pixel fill is taken on the first IDLE cycle
    send(32'h0200_0111);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_data  = 32'h0005_0699;
    check("held_noack0", 32'(cmd_if.cmd_ack), 32'd0);
    tick();
    check("held_noack1", 32'(cmd_if.cmd_ack), 32'd0);
    check("held_fill_addr", 32'(waddr), 32'h0001);
    tick();
    check("held_ack", 32'(cmd_if.cmd_ack), 32'd1);
    check("held_gap_wen", 32'(wen), 32'd0);
    tick();
    cmd_if.cmd_valid = 1'b0;
    check("held_pix_wen", 32'(wen), 32'd1);
    check("held_pix_addr", 32'(waddr), 32'h0506);
    check("held_pix_data", 32'(wdata), 32'h99);
    tick();

    // Unknown opcode: acked and dropped; abort while idle is ignored
    abort = 1'b1;
    send(32'h7F00_0101);
    check("badop_wen", 32'(wen), 32'd0);
    check("badop_busy", 32'(busy), 32'd0);
    check("badop_ack", 32'(cmd_if.cmd_ack), 32'd1);
    send(32'h0002_0333);
    abort = 1'b0;
    check("idle_abort_wen", 32'(wen), 32'd1);
    check("idle_abort_addr", 32'(waddr), 32'h0203);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
